// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered instruction decode stage with stall, flush and decode counter
module instr_decode_stage #(
  parameter int DBITS        = 32,
  parameter int INSTR_BITS   = 32,
  parameter int REG_IDX_BITS = 4,
  parameter int OP_BITS      = 4,
  parameter int IMM_BITS     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INSTR_BITS-1:0]   instr_in,
  input  logic [DBITS-1:0]        pc_in,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [OP_BITS-1:0]      op1_q,
  output logic [OP_BITS-1:0]      op2_q,
  output logic [REG_IDX_BITS-1:0] rd_q,
  output logic [REG_IDX_BITS-1:0] rs1_q,
  output logic [REG_IDX_BITS-1:0] rs2_q,
  output logic [DBITS-1:0]        imm_q,
  output logic [DBITS-1:0]        pc_q,
  output logic                    use_imm_q,
  output logic                    reg_we_q,
  output logic                    is_br_q,
  output logic                    is_jal_q,
  output logic                    is_lw_q,
  output logic                    is_sw_q,
  output logic                    illegal_q,
  output logic                    out_valid_q,
  output logic [31:0]             dec_count
);

  localparam logic [OP_BITS-1:0] OP_ALUR  = 4'b0000;
  localparam logic [OP_BITS-1:0] OP_ALUI  = 4'b1000;
  localparam logic [OP_BITS-1:0] OP_CMPR  = 4'b0010;
  localparam logic [OP_BITS-1:0] OP_CMPI  = 4'b1010;
  localparam logic [OP_BITS-1:0] OP_BCOND = 4'b0110;
  localparam logic [OP_BITS-1:0] OP_SW    = 4'b0101;
  localparam logic [OP_BITS-1:0] OP_LW    = 4'b1001;
  localparam logic [OP_BITS-1:0] OP_JAL   = 4'b1011;
  localparam logic [OP_BITS-1:0] OP2_MVHI = 4'b1011;

  logic [OP_BITS-1:0]      op1, op2;
  logic [REG_IDX_BITS-1:0] rd, rs1, rs2;
  logic [IMM_BITS-1:0]     imm16;
  logic [DBITS-1:0]        imm_ext;
  logic legal, use_imm, reg_we, is_br, is_jal, is_lw, is_sw;

  assign op1   = instr_in[31:28];
  assign op2   = instr_in[27:24];
  assign rd    = instr_in[23:20];
  assign rs1   = instr_in[19:16];
  assign rs2   = instr_in[15:12];
  assign imm16 = instr_in[15:0];

  // MVHI places imm16 in the upper half; branch/JAL offsets stay in words.
  assign imm_ext = (op1 == OP_ALUI && op2 == OP2_MVHI)
                 ? {imm16, {(DBITS-IMM_BITS){1'b0}}}
                 : {{(DBITS-IMM_BITS){imm16[IMM_BITS-1]}}, imm16};

  always_comb begin
    legal   = 1'b1;
    use_imm = 1'b0;
    reg_we  = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    case (op1)
      OP_ALUR:  reg_we = 1'b1;
      OP_CMPR:  reg_we = 1'b1;
      OP_ALUI:  begin reg_we = 1'b1; use_imm = 1'b1; end
      OP_CMPI:  begin reg_we = 1'b1; use_imm = 1'b1; end
      OP_BCOND: begin is_br = 1'b1; use_imm = 1'b1; end
      OP_SW:    begin is_sw = 1'b1; use_imm = 1'b1; end
      OP_LW:    begin is_lw = 1'b1; reg_we = 1'b1; use_imm = 1'b1; end
      OP_JAL:   begin is_jal = 1'b1; reg_we = 1'b1; use_imm = 1'b1; end
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      use_imm_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      is_br_q     <= 1'b0;
      is_jal_q    <= 1'b0;
      is_lw_q     <= 1'b0;
      is_sw_q     <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      if (reset) dec_count <= '0;
    end else if (!stall) begin
      op1_q       <= op1;
      op2_q       <= op2;
      rd_q        <= rd;
      rs1_q       <= rs1;
      rs2_q       <= rs2;
      imm_q       <= imm_ext;
      pc_q        <= pc_in;
      // Invalid slots carry fields but no control, so they behave as bubbles.
      use_imm_q   <= in_valid & use_imm;
      reg_we_q    <= in_valid & reg_we;
      is_br_q     <= in_valid & is_br;
      is_jal_q    <= in_valid & is_jal;
      is_lw_q     <= in_valid & is_lw;
      is_sw_q     <= in_valid & is_sw;
      illegal_q   <= in_valid & ~legal;
      out_valid_q <= in_valid;
      if (in_valid) dec_count <= dec_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - self-checking bench for instr_decode_stage
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [31:0] instr_in, pc_in;
  logic [3:0]  op1_q, op2_q, rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q, pc_q, dec_count;
  logic        use_imm_q, reg_we_q, is_br_q, is_jal_q, is_lw_q, is_sw_q, illegal_q, out_valid_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in), .in_valid(in_valid),
    .stall(stall), .flush(flush), .op1_q(op1_q), .op2_q(op2_q), .rd_q(rd_q), .rs1_q(rs1_q),
    .rs2_q(rs2_q), .imm_q(imm_q), .pc_q(pc_q), .use_imm_q(use_imm_q), .reg_we_q(reg_we_q),
    .is_br_q(is_br_q), .is_jal_q(is_jal_q), .is_lw_q(is_lw_q), .is_sw_q(is_sw_q),
    .illegal_q(illegal_q), .out_valid_q(out_valid_q), .dec_count(dec_count)
  );

  typedef struct packed {
    logic [3:0]  op1, op2, rd, rs1, rs2;
    logic [31:0] imm, pc;
    logic        use_imm, reg_we, is_br, is_jal, is_lw, is_sw, illegal, out_valid;
    logic [31:0] cnt;
  } out_t;

  // flags = {use_imm, reg_we, is_br, is_jal, is_lw, is_sw, illegal}
  typedef struct packed {
    logic [31:0] instr, pc;
    logic [3:0]  op1, op2, rd, rs1, rs2;
    logic [31:0] imm;
    logic [6:0]  flags;
  } vec_t;

  out_t exp_o;
  vec_t tv [12];

  function automatic out_t act_bundle();
    return {op1_q, op2_q, rd_q, rs1_q, rs2_q, imm_q, pc_q, use_imm_q, reg_we_q, is_br_q,
            is_jal_q, is_lw_q, is_sw_q, illegal_q, out_valid_q, dec_count};
  endfunction

  // Reference decode: classes by opcode membership, immediate by arithmetic.
  function automatic out_t model_load(logic [31:0] ins, logic [31:0] pc, logic v, logic [31:0] cnt);
    out_t o;
    int   op;
    int   raw;
    o    = '0;
    op   = int'(ins[31:28]);
    raw  = int'(ins[15:0]);
    o.op1 = ins[31:28]; o.op2 = ins[27:24]; o.rd = ins[23:20];
    o.rs1 = ins[19:16]; o.rs2 = ins[15:12]; o.pc = pc;
    if (op == 8 && ins[27:24] == 4'd11) o.imm = 32'(raw * 65536);
    else                                o.imm = 32'(raw >= 32768 ? raw - 65536 : raw);
    o.cnt = cnt;
    if (v) begin
      o.out_valid = 1'b1;
      o.cnt       = cnt + 32'd1;
      o.illegal   = !(op inside {0, 8, 2, 10, 6, 5, 9, 11});
      o.reg_we    = op inside {0, 8, 2, 10, 9, 11};
      o.use_imm   = op inside {8, 10, 6, 5, 9, 11};
      o.is_br     = (op == 6);
      o.is_jal    = (op == 11);
      o.is_lw     = (op == 9);
      o.is_sw     = (op == 5);
    end
    return o;
  endfunction

  task automatic check(input string name, input out_t e);
    out_t a;
    a = act_bundle();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, a, e);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, a, e);
    end
  endtask

  // Drive at a falling edge, advance the model for the rising edge, check at the next falling edge.
  task automatic step(input logic r, input logic f, input logic s, input logic v,
                      input logic [31:0] ins, input logic [31:0] pc, input string name);
    logic [31:0] c;
    reset = r; flush = f; stall = s; in_valid = v; instr_in = ins; pc_in = pc;
    if (r) exp_o = '0;
    else if (f) begin
      c = exp_o.cnt; exp_o = '0; exp_o.cnt = c;
    end else if (!s) exp_o = model_load(ins, pc, v, exp_o.cnt);
    @(negedge clk);
    check(name, exp_o);
  endtask

  initial begin
    out_t        e;
    logic [31:0] held, ri;
    tv[0]  = {32'h80120005, 32'h44,  4'h8, 4'h0, 4'h1, 4'h2, 4'h0, 32'h00000005, 7'b1100000};
    tv[1]  = {32'h6001FFFC, 32'h48,  4'h6, 4'h0, 4'h0, 4'h1, 4'hF, 32'hFFFFFFFC, 7'b1010000};
    tv[2]  = {32'h8B30ABCD, 32'h4C,  4'h8, 4'hB, 4'h3, 4'h0, 4'hA, 32'hABCD0000, 7'b1100000};
    tv[3]  = {32'h01234000, 32'h50,  4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 32'h00004000, 7'b0100000};
    tv[4]  = {32'h95678000, 32'h54,  4'h9, 4'h5, 4'h6, 4'h7, 4'h8, 32'hFFFF8000, 7'b1100100};
    tv[5]  = {32'h5ABC1234, 32'h58,  4'h5, 4'hA, 4'hB, 4'hC, 4'h1, 32'h00001234, 7'b1000010};
    tv[6]  = {32'hB0D0FFFF, 32'h5C,  4'hB, 4'h0, 4'hD, 4'h0, 4'hF, 32'hFFFFFFFF, 7'b1101000};
    tv[7]  = {32'h23456789, 32'h60,  4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 32'h00006789, 7'b0100000};
    tv[8]  = {32'hA1F28001, 32'h64,  4'hA, 4'h1, 4'hF, 4'h2, 4'h8, 32'hFFFF8001, 7'b1100000};
    tv[9]  = {32'hF1234567, 32'h68,  4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 32'h00004567, 7'b0000001};
    tv[10] = {32'hAB001234, 32'h6C,  4'hA, 4'hB, 4'h0, 4'h0, 4'h1, 32'h00001234, 7'b1100000};
    tv[11] = {32'h34567FFF, 32'h70,  4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 32'h00007FFF, 7'b0000001};

    exp_o = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 32'h0, 32'h0, "reset");
    step(0, 0, 0, 0, 32'h0, 32'h0, "idle_after_reset");
    check32("reset_dec_count", dec_count, 32'h0);

    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, tv[i].instr, tv[i].pc, "table_model");
      e = {tv[i].op1, tv[i].op2, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].imm, tv[i].pc,
           tv[i].flags, 1'b1, 32'(i + 1)};
      check($sformatf("table_%0d", i), e);
    end

    step(0, 0, 0, 1, 32'h80120005, 32'h200, "stall_load");
    held = dec_count;
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 32'h95678000 + k, 32'h300 + k, "stall_hold");
    check32("stall_count_held", dec_count, held);
    step(0, 0, 0, 1, 32'h6001FFFC, 32'h204, "stall_release");
    check32("stall_release_imm", imm_q, 32'hFFFFFFFC);

    step(0, 1, 1, 1, 32'h80120005, 32'h208, "flush_and_stall");
    check32("flush_count_held", dec_count, held + 32'd1);

    step(0, 0, 1, 1, 32'h01234000, 32'h20C, "stall_before_reset");
    step(1, 0, 1, 1, 32'h01234000, 32'h20C, "reset_mid_stall");
    step(0, 0, 0, 1, 32'hF0000000, 32'h210, "illegal_after_reset");

    @(negedge clk);
    force dut.dec_count = 32'hFFFFFFFF;
    #1 release dut.dec_count;
    exp_o.cnt = 32'hFFFFFFFF;
    step(0, 0, 1, 0, 32'h0, 32'h0, "count_forced");
    step(0, 0, 0, 1, 32'hB0D0FFFF, 32'h214, "count_wrap");
    check32("count_wrap_zero", dec_count, 32'h0);

    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 7) == 0) ri[31:24] = 8'h8B;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) != 0, ri, $urandom, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
